imm_gen_pipe: RTL and testbench

//  Pipelined, parametrised immediate generator between fetch and execute.

---
 rtl/imm_gen_pipe.sv | 171 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: decodes {instr, pc} into imm/target/format behind a 2-entry buffer.
// Optional RVC quadrant-01 subset is enabled by defining IMM_GEN_RVC_EN.
`timescale 1ns/1ps

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  // Handshake: a beat moves when valid && ready on a rising edge; valid may not depend on ready,
  // and in_ready comes from the stored entry count only (never from out_ready).
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_I   = 3'd0;
  localparam logic [2:0] FMT_S   = 3'd1;
  localparam logic [2:0] FMT_B   = 3'd2;
  localparam logic [2:0] FMT_J   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_R   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
  } entry_t;

  logic [6:0]      opcode;
  logic [31:0]     raw_imm;   // immediate already sign-extended to 32 bits
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;

  assign opcode = in_instr[6:0];

`ifdef IMM_GEN_RVC_EN
  logic [15:0] ci;
  assign ci = in_instr[15:0];
`endif

  always_comb begin
    raw_imm = '0;
    dec_fmt = FMT_ILL;
    if (in_instr[1:0] == 2'b11) begin
      case (opcode)
        7'b0010011, 7'b0000011, 7'b1100111: begin
          dec_fmt = FMT_I;
          raw_imm = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        7'b0011011: begin
          // ADDIW-class word ops only exist on RV64
          if (XLEN == 64) begin
            dec_fmt = FMT_I;
            raw_imm = {{20{in_instr[31]}}, in_instr[31:20]};
          end
        end
        7'b0100011: begin
          dec_fmt = FMT_S;
          raw_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        7'b1100011: begin
          dec_fmt = FMT_B;
          raw_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
        end
        7'b1101111: begin
          dec_fmt = FMT_J;
          raw_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec_fmt = FMT_U;
          raw_imm = {in_instr[31:12], 12'b0};
        end
        7'b0110011: begin
          dec_fmt = FMT_R;
        end
        default: ;
      endcase
    end else begin
`ifdef IMM_GEN_RVC_EN
      if (ci[1:0] == 2'b01) begin
        case (ci[15:13])
          3'b000, 3'b010: begin
            dec_fmt = FMT_I;
            raw_imm = {{26{ci[12]}}, ci[12], ci[6:2]};
          end
          3'b101: begin
            dec_fmt = FMT_J;
            raw_imm = {{20{ci[12]}}, ci[12], ci[8], ci[10:9], ci[6], ci[7], ci[2], ci[11],
                       ci[5:3], 1'b0};
          end
          3'b110, 3'b111: begin
            dec_fmt = FMT_B;
            raw_imm = {{23{ci[12]}}, ci[12], ci[6:5], ci[2], ci[11:10], ci[4:3], 1'b0};
          end
          default: ;
        endcase
      end
`endif
    end
  end

  assign dec_imm    = XLEN'($signed(raw_imm));
  assign dec_target = (dec_fmt == FMT_ILL) ? '0 : in_pc + dec_imm;

  entry_t           slot_q [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic [CNT_W-1:0] cnt_q;
  logic             push;
  logic             pop;
  entry_t           head;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
      if (push && (dec_fmt == FMT_ILL) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Payload needs no reset: it is only visible while count says it is valid
  always_ff @(posedge clk) begin
    if (push) begin
      slot_q[wr_ptr] <= {dec_imm, dec_target, dec_fmt};
    end
  end

  assign head        = out_valid ? slot_q[rd_ptr] : '0;
  assign out_imm     = head.imm;
  assign out_target  = head.target;
  assign out_fmt     = head.fmt;
  assign out_illegal = (head.fmt == FMT_ILL);
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32/CNT_W=2 and an XLEN=64/CNT_W=16 instance share one stimulus stream
// and are compared every cycle against an arithmetic reference model plus pinned literal cases.
`timescale 1ns/1ps

module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        rdy32, v32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  fmt32;
  logic [1:0]  cnt32;

  logic        rdy64, v64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt64;
  logic [15:0] cnt64;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
    .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready), .out_imm(imm32),
    .out_target(tgt32), .out_fmt(fmt32), .out_illegal(ill32), .illegal_cnt(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready), .out_imm(imm64),
    .out_target(tgt64), .out_fmt(fmt64), .out_illegal(ill64), .illegal_cnt(cnt64)
  );

  typedef struct packed {
    logic [31:0] imm32;
    logic [31:0] tgt32;
    logic [2:0]  fmt32;
    logic [63:0] imm64;
    logic [63:0] tgt64;
    logic [2:0]  fmt64;
  } exp_t;

  exp_t exp_q[$];
  int   c32 = 0;
  int   c64 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
    end
  endtask

  // Interpret the low n bits of raw as a two's-complement number
  function automatic longint sx(input logic [31:0] raw, input int n);
    longint u, one;
    u   = longint'({32'b0, raw});
    one = 1;
    if (u >= (one << (n - 1))) u = u - (one << n);
    return u;
  endfunction

  function automatic void ref_dec(input logic [31:0] w, input bit is64,
                                  output logic [63:0] imm, output logic [2:0] fmt);
    longint v;
    v   = 0;
    fmt = 3'd7;
    if (w[1:0] == 2'b11) begin
      case (w[6:0])
        7'h13, 7'h03, 7'h67: begin fmt = 3'd0; v = sx(32'(w[31:20]), 12); end
        7'h1B: if (is64) begin fmt = 3'd0; v = sx(32'(w[31:20]), 12); end
        7'h23: begin fmt = 3'd1; v = sx(32'({w[31:25], w[11:7]}), 12); end
        7'h63: begin fmt = 3'd2; v = sx(32'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13); end
        7'h6F: begin fmt = 3'd3; v = sx(32'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21); end
        7'h37, 7'h17: begin fmt = 3'd4; v = sx({w[31:12], 12'b0}, 32); end
        7'h33: fmt = 3'd5;
        default: ;
      endcase
    end
`ifdef IMM_GEN_RVC_EN
    else if (w[1:0] == 2'b01) begin
      case (w[15:13])
        3'b000, 3'b010: begin fmt = 3'd0; v = sx(32'({w[12], w[6:2]}), 6); end
        3'b101: begin
          fmt = 3'd3;
          v = sx(32'({w[12], w[8], w[10:9], w[6], w[7], w[2], w[11], w[5:3], 1'b0}), 12);
        end
        3'b110, 3'b111: begin
          fmt = 3'd2;
          v = sx(32'({w[12], w[6:5], w[2], w[11:10], w[4:3], 1'b0}), 9);
        end
        default: ;
      endcase
    end
`endif
    imm = v;
  endfunction

  function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
    exp_t        e;
    logic [63:0] v;
    logic [2:0]  f;
    ref_dec(w, 1'b0, v, f);
    e.fmt32 = f;
    e.imm32 = v[31:0];
    e.tgt32 = (f == 3'd7) ? 32'h0 : pc[31:0] + v[31:0];
    ref_dec(w, 1'b1, v, f);
    e.fmt64 = f;
    e.imm64 = v;
    e.tgt64 = (f == 3'd7) ? 64'h0 : pc + v;
    return e;
  endfunction

  // Reference buffer: what the consumer must see, updated with the pre-edge inputs
  always @(posedge clk) begin
    bit   do_push, do_pop;
    exp_t e;
    if (reset) begin
      exp_q.delete();
      c32 = 0;
      c64 = 0;
    end else begin
      do_pop  = out_ready && (exp_q.size() != 0);
      do_push = in_valid && (exp_q.size() < 2);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        e = model(in_instr, in_pc);
        exp_q.push_back(e);
        if (e.fmt32 == 3'd7 && c32 < 3) c32++;
        if (e.fmt64 == 3'd7 && c64 < 65535) c64++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t h;
    bit   nz;
    if (chk_en) begin
      nz = (exp_q.size() != 0);
      h  = nz ? exp_q[0] : '0;
      chk("in_ready32", 64'(rdy32), 64'(exp_q.size() < 2));
      chk("out_valid32", 64'(v32), 64'(nz));
      chk("imm32", 64'(imm32), 64'(h.imm32));
      chk("target32", 64'(tgt32), 64'(h.tgt32));
      chk("fmt32", 64'(fmt32), 64'(h.fmt32));
      chk("illegal32", 64'(ill32), 64'(nz && h.fmt32 == 3'd7));
      chk("cnt32", 64'(cnt32), 64'(c32));
      chk("in_ready64", 64'(rdy64), 64'(exp_q.size() < 2));
      chk("out_valid64", 64'(v64), 64'(nz));
      chk("imm64", imm64, h.imm64);
      chk("target64", tgt64, h.tgt64);
      chk("fmt64", 64'(fmt64), 64'(h.fmt64));
      chk("illegal64", 64'(ill64), 64'(nz && h.fmt64 == 3'd7));
      chk("cnt64", 64'(cnt64), 64'(c64));
    end
  end

  task automatic push1(input logic [31:0] w, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] w;
    ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};
    w = $urandom;
    case ($urandom_range(0, 6))
      0, 1, 2: w[6:0] = ops[$urandom_range(0, 9)];
      3, 4:    w[1:0] = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
      5:       w = 32'hFFFF_FFFF;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int cseq [5];
    cseq = '{1, 2, 3, 3, 3};
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(v32), 64'd0);
    chk("rst_in_ready", 64'(rdy32), 64'd1);
    chk("rst_imm", imm64, 64'd0);
    chk("rst_cnt", 64'(cnt32), 64'd0);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;

    // addi x1,x0,-1
    push1(32'hFFF0_0093, 64'h100);
    @(negedge clk);
    chk("addi_imm", 64'(imm32), 64'hFFFF_FFFF);
    chk("addi_fmt", 64'(fmt32), 64'd0);
    chk("addi_target", 64'(tgt32), 64'hFF);

    // beq -4, then jal +2048
    push1(32'hFE00_0EE3, 64'h200);
    @(negedge clk);
    chk("beq_imm", 64'(imm32), 64'hFFFF_FFFC);
    chk("beq_fmt", 64'(fmt32), 64'd2);
    chk("beq_target", 64'(tgt32), 64'h1FC);
    push1(32'h0010_006F, 64'h200);
    @(negedge clk);
    chk("jal_imm", 64'(imm32), 64'h800);

    // auipc on RV64
    push1(32'h8000_0017, 64'h1000);
    @(negedge clk);
    chk("auipc64_imm", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("auipc64_target", tgt64, 64'hFFFF_FFFF_8000_1000);

    // backpressure: three words, only two fit
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push1(32'h0010_0013, 64'h0);
    in_valid = 1'b1;
    in_instr = 32'h0020_0013;
    @(posedge clk);
    #1;
    in_instr = 32'h0030_0013;
    @(negedge clk);
    chk("full_in_ready", 64'(rdy32), 64'd0);
    chk("full_head1", 64'(imm32), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("hold_head1", 64'(imm32), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("order_2", 64'(imm32), 64'd2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("order_3", 64'(imm32), 64'd3);
    @(posedge clk);
    @(negedge clk);
    chk("drained", 64'(v32), 64'd0);

    // illegal counter saturation at CNT_W=2
    do_reset();
    in_valid = 1'b1;
    in_instr = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("sat_cnt", 64'(cnt32), 64'(cseq[k]));
      chk("sat_illegal", 64'(ill32), 64'd1);
      chk("sat_imm", 64'(imm32), 64'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // compressed c.li x1,-1
    push1(32'h0000_50FD, 64'h40);
    @(negedge clk);
`ifdef IMM_GEN_RVC_EN
    chk("cli_imm", 64'(imm32), 64'hFFFF_FFFF);
    chk("cli_fmt", 64'(fmt32), 64'd0);
`else
    chk("cli_fmt", 64'(fmt32), 64'd7);
`endif

    // reset with two entries buffered
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push1(32'h0050_0013, 64'h0);
    push1(32'h0060_0013, 64'h0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 64'(v32), 64'd0);
    chk("midrst_in_ready", 64'(rdy32), 64'd1);
    reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      reset     = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = {$urandom, $urandom};
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
